// File: rtl/cf_bcd_tick_counter.sv
// cf_bcd_tick_counter
// Samples the divider's slow_clk as data and turns each rising edge into a
// one-cycle tick. Ticks are counted in a packed BCD up/down counter that is
// gated by a small run/pause/clear state machine.

module cf_bcd_tick_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  slow_clk,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  running,
  output logic [1:0]            state
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           s1;
  logic           s2;
  logic           s3;
  logic [W-1:0]   count_q;
  logic [W-1:0]   count_step;
  logic           roll;
  logic           wrap_q;

  // Three-flop chain: s1/s2 synchronise slow_clk, s3 remembers the previous level
  always_ff @(posedge clk) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear dominates, then start, then stop
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stop)  state_d = PAUSE;
        PAUSE:   if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state only
  always_comb begin
    state   = state_q;
    running = (state_q == RUN);
  end

  // One BCD step in the requested direction; roll survives only if every digit wrapped
  always_comb begin
    count_step = count_q;
    roll       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (roll) begin
        if (dir) begin
          if (count_q[4*i +: 4] >= 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            roll                 = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            roll                 = 1'b0;
          end
        end
      end
    end
  end

  // Count register: clear beats a coincident tick, ticks only count while already in RUN
  always_ff @(posedge clk) begin
    if (RST) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (tick && (state_q == RUN)) begin
      count_q <= count_step;
      wrap_q  <= roll;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
